core_rvfi_sequencer: RTL and testbench
======================================

// Module: core_rvfi_sequencer
//
// PURPOSE
//   In-order retirement sequencer in front of the RVFI trace outputs. Holds
//   retired-instruction records until each has all of its trace data,
//   including load/store responses that arrive after retirement. Releases
//   exactly one complete record per cycle, in program order, as a
//   single-cycle pulse for the formal/trace monitor. Sits between the
//   writeback stage and the RVFI output register.
//
// PARAMETERS
//   DEPTH  4   queue entries; power of 2, >= 2
//   REC_W  256 packed retire record width (insn/pc/rs/rd fields)
//   XLEN   64  memory response data width
//
// PORTS
//   g_clk           in  1      clock
//   g_resetn        in  1      synchronous active-low reset
//   i_ret_valid     in  1      retire record offered this cycle
//   i_ret_ready     out 1      queue accepts a record (= !full)
//   i_ret_rec       in  REC_W  packed retire record
//   i_ret_mem       in  1      record is a memory op awaiting a response
//   i_mem_rsp_valid in  1      memory response beat (in request order)
//   i_mem_rsp_rdata in  XLEN   memory response read data
//   o_valid         out 1      released-record pulse
//   o_rec           out REC_W  released record
//   o_mem_rdata     out XLEN   response data of released record (0 if none)
//   o_count         out clog2(DEPTH)+1 current occupancy
//   o_err           out 1      sticky protocol-error flag
//
// BEHAVIOUR
// - Reset (g_resetn=0 at posedge): rd/wr/mem pointers=0; all entries
//   invalid; o_valid=0; o_rec=0; o_mem_rdata=0; o_count=0; o_err=0.
//   Reset mid-operation discards every pending record; no partial release.
// - Entry fields: rec, needs_mem, mem_done, rdata.
// - Push: i_ret_valid && i_ret_ready writes the entry at wr_ptr;
//   needs_mem=i_ret_mem; mem_done=0; wr_ptr++ (wraps at DEPTH).
// - Memory pointer (mem_ptr): oldest entry with needs_mem && !mem_done.
//   A response sets that entry's mem_done=1 and rdata=i_mem_rsp_rdata.
//   Entries with needs_mem=0 are skipped.
// - Same-cycle push and response, with no older entry awaiting a response:
//   the response binds to the record being pushed (mem_done=1 on write).
// - Response while nothing is outstanding, and not bound as above: dropped;
//   o_err <= 1.
// - Release: head entry is eligible when valid && (!needs_mem || mem_done).
//   An eligible head pops at the clock edge and rd_ptr advances.
//   Next cycle: o_valid=1, and o_rec/o_mem_rdata take the entry's values
//   (o_mem_rdata=0 if needs_mem=0). Otherwise o_valid=0 and data holds.
// - Latency: a non-memory record pushed in cycle N, into an empty queue,
//   gives o_valid in cycle N+2. A memory record's head response in cycle M
//   gives o_valid in cycle M+2.
// - At most one push and one pop per cycle. Simultaneous push and pop
//   leaves o_count unchanged.
// - i_ret_ready is derived from registered occupancy only: a same-cycle
//   pop does not make a full queue ready.
// - i_ret_valid while full: record dropped; o_err <= 1.
// - o_err clears only on reset.
//
// CONFIGURATION
// - RVFI_SEQ_DROP_FIRST_EN defined: the first record released after reset
//   is popped but suppressed (o_valid stays 0; o_rec not updated). Later
//   releases behave normally. This matches the RVFI first-retire masking.
// - Undefined: every released record produces an o_valid pulse.
//
// TESTING
// 1. Reset, push rec A (no mem) at cycle 5 -> o_valid=1 in cycle 7 with
//    o_rec=A, o_mem_rdata=0 (macro off); with macro on, no pulse.
// 2. Push load L (mem) at cycle 0, ALU op B at cycle 1, response 0xDEAD at
//    cycle 6 -> L released at cycle 8 with rdata 0xDEAD, B at cycle 9.
// 3. Push DEPTH=4 mem records with no responses -> i_ret_ready=0,
//    o_count=4. Fifth push -> dropped and o_err=1.
// 4. Push mem record and response in the same cycle, empty queue ->
//    o_valid 2 cycles later carrying that rdata.
// 5. Response with queue empty -> o_err=1, o_valid stays 0, o_count=0.
// 6. Assert g_resetn=0 with 3 pending -> next cycle o_count=0, o_valid=0;
//    late response after reset -> o_err=1.

Source files
------------

// File: rtl/core_rvfi_sequencer_if.sv
// Retire/response/release bundle between writeback, the RVFI sequencer and the
// trace output register.
interface core_rvfi_sequencer_if #(
  parameter int REC_W = 256,
  parameter int XLEN  = 64
);
  logic             i_ret_valid;
  logic             i_ret_ready;
  logic [REC_W-1:0] i_ret_rec;
  logic             i_ret_mem;
  logic             i_mem_rsp_valid;
  logic [XLEN-1:0]  i_mem_rsp_rdata;
  logic             o_valid;
  logic [REC_W-1:0] o_rec;
  logic [XLEN-1:0]  o_mem_rdata;

  modport master (
    output i_ret_valid, i_ret_rec, i_ret_mem, i_mem_rsp_valid, i_mem_rsp_rdata,
    input  i_ret_ready, o_valid, o_rec, o_mem_rdata
  );

  modport slave (
    input  i_ret_valid, i_ret_rec, i_ret_mem, i_mem_rsp_valid, i_mem_rsp_rdata,
    output i_ret_ready, o_valid, o_rec, o_mem_rdata
  );
endinterface

// File: rtl/core_rvfi_sequencer.sv
// In-order RVFI retirement sequencer: holds retired records until their memory
// responses arrive, then releases one per cycle. Option: RVFI_SEQ_DROP_FIRST_EN.
module core_rvfi_sequencer #(
  parameter int DEPTH = 4,
  parameter int REC_W = 256,
  parameter int XLEN  = 64
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  core_rvfi_sequencer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REC_W-1:0] rec_q   [DEPTH];
  logic [REC_W-1:0] rec_d   [DEPTH];
  logic [XLEN-1:0]  rdata_q [DEPTH];
  logic [XLEN-1:0]  rdata_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] needs_mem_q, needs_mem_d;
  logic [DEPTH-1:0] mem_done_q, mem_done_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             o_valid_q, o_valid_d;
  logic [REC_W-1:0] o_rec_q, o_rec_d;
  logic [XLEN-1:0]  o_mem_rdata_q, o_mem_rdata_d;
  logic             err_q, err_d;
  logic             first_done_q, first_done_d;

  logic             full;
  logic             push;
  logic             pop;
  logic             release_rec;
  logic             rsp_old;
  logic             rsp_new;
  logic             rsp_drop;
  logic [PW-1:0]    mem_ptr;
  logic             mem_pend;
  logic [PW-1:0]    scan_idx;
  logic             scan_hit;

  assign full            = (count_q == CW'(DEPTH));
  assign bus.i_ret_ready = ~full;
  assign bus.o_valid     = o_valid_q;
  assign bus.o_rec       = o_rec_q;
  assign bus.o_mem_rdata = o_mem_rdata_q;
  assign o_count         = count_q;
  assign o_err           = err_q;

  // Oldest queued entry still waiting on a response, scanning from the head.
  always_comb begin
    mem_ptr  = rd_ptr_q;
    mem_pend = 1'b0;
    scan_idx = rd_ptr_q;
    scan_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PW'(i);
      scan_hit = ~mem_pend & valid_q[scan_idx] & needs_mem_q[scan_idx] & ~mem_done_q[scan_idx];
      mem_ptr  = scan_hit ? scan_idx : mem_ptr;
      mem_pend = mem_pend | scan_hit;
    end
  end

  // Push, response binding, pop and release decode.
  always_comb begin
    rec_d         = rec_q;
    rdata_d       = rdata_q;
    valid_d       = valid_q;
    needs_mem_d   = needs_mem_q;
    mem_done_d    = mem_done_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    o_valid_d     = 1'b0;
    o_rec_d       = o_rec_q;
    o_mem_rdata_d = o_mem_rdata_q;
    first_done_d  = first_done_q;

    push     = bus.i_ret_valid & ~full;
    pop      = valid_q[rd_ptr_q] & (~needs_mem_q[rd_ptr_q] | mem_done_q[rd_ptr_q]);
    rsp_old  = bus.i_mem_rsp_valid & mem_pend;
    // With nothing older outstanding, a response may bind to the record entering now.
    rsp_new  = bus.i_mem_rsp_valid & ~mem_pend & push & bus.i_ret_mem;
    rsp_drop = bus.i_mem_rsp_valid & ~rsp_old & ~rsp_new;

`ifdef RVFI_SEQ_DROP_FIRST_EN
    release_rec  = pop & first_done_q;
    first_done_d = first_done_q | pop;
`else
    release_rec  = pop;
`endif

    if (push) begin
      rec_d[wr_ptr_q]       = bus.i_ret_rec;
      valid_d[wr_ptr_q]     = 1'b1;
      needs_mem_d[wr_ptr_q] = bus.i_ret_mem;
      mem_done_d[wr_ptr_q]  = rsp_new;
      rdata_d[wr_ptr_q]     = rsp_new ? bus.i_mem_rsp_rdata : {XLEN{1'b0}};
      wr_ptr_d              = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rsp_old) begin
      mem_done_d[mem_ptr] = 1'b1;
      rdata_d[mem_ptr]    = bus.i_mem_rsp_rdata;
    end else begin
      mem_done_d[mem_ptr] = mem_done_d[mem_ptr];
    end

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (release_rec) begin
      o_valid_d     = 1'b1;
      o_rec_d       = rec_q[rd_ptr_q];
      o_mem_rdata_d = needs_mem_q[rd_ptr_q] ? rdata_q[rd_ptr_q] : {XLEN{1'b0}};
    end else begin
      o_valid_d = 1'b0;
    end

    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    err_d   = err_q | rsp_drop | (bus.i_ret_valid & full);
  end

  // Control state and outputs, cleared by the synchronous reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      valid_q       <= {DEPTH{1'b0}};
      needs_mem_q   <= {DEPTH{1'b0}};
      mem_done_q    <= {DEPTH{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      count_q       <= {CW{1'b0}};
      o_valid_q     <= 1'b0;
      o_rec_q       <= {REC_W{1'b0}};
      o_mem_rdata_q <= {XLEN{1'b0}};
      err_q         <= 1'b0;
      first_done_q  <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      needs_mem_q   <= needs_mem_d;
      mem_done_q    <= mem_done_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      o_valid_q     <= o_valid_d;
      o_rec_q       <= o_rec_d;
      o_mem_rdata_q <= o_mem_rdata_d;
      err_q         <= err_d;
      first_done_q  <= first_done_d;
    end
  end

  // Payload storage; only meaningful while the matching valid bit is set.
  always_ff @(posedge g_clk) begin
    rec_q   <= rec_d;
    rdata_q <= rdata_d;
  end
endmodule

// File: tb/tb_core_rvfi_sequencer.sv
// Directed bench for core_rvfi_sequencer; honours RVFI_SEQ_DROP_FIRST_EN.
module tb_core_rvfi_sequencer;
  localparam int DEPTH = 4;
  localparam int REC_W = 256;
  localparam int XLEN  = 64;
`ifdef RVFI_SEQ_DROP_FIRST_EN
  localparam bit DROP_FIRST = 1'b1;
`else
  localparam bit DROP_FIRST = 1'b0;
`endif

  logic       g_clk = 1'b0;
  logic       g_resetn;
  logic [2:0] o_count;
  logic       o_err;
  int         n_checks = 0;
  int         n_pass   = 0;

  logic [REC_W-1:0] rec_a, rec_l, rec_b, rec_c, rec_m;
  logic [REC_W-1:0] rec_r [5];

  core_rvfi_sequencer_if #(.REC_W(REC_W), .XLEN(XLEN)) bus ();

  core_rvfi_sequencer #(.DEPTH(DEPTH), .REC_W(REC_W), .XLEN(XLEN)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus),
    .o_count  (o_count),
    .o_err    (o_err)
  );

  always #5 g_clk = ~g_clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle();
    bus.i_ret_valid     = 1'b0;
    bus.i_ret_rec       = '0;
    bus.i_ret_mem       = 1'b0;
    bus.i_mem_rsp_valid = 1'b0;
    bus.i_mem_rsp_rdata = '0;
  endtask

  task automatic push(input logic [REC_W-1:0] rec, input logic mem);
    bus.i_ret_valid = 1'b1;
    bus.i_ret_rec   = rec;
    bus.i_ret_mem   = mem;
  endtask

  task automatic rsp(input logic [XLEN-1:0] data);
    bus.i_mem_rsp_valid = 1'b1;
    bus.i_mem_rsp_rdata = data;
  endtask

  initial begin
    rec_a = {8{32'hA0A0_0001}};
    rec_l = {8{32'h1D1D_0002}};
    rec_b = {8{32'hB0B0_0003}};
    rec_c = {8{32'hC0C0_0004}};
    rec_m = {8{32'h3E3E_0005}};
    for (int k = 0; k < 5; k++) rec_r[k] = {8{32'h5000_0000 + 32'(k)}};

    idle();
    g_resetn = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", bus.o_valid, 1'b0);
    check_eq("rst_rec", bus.o_rec, '0);
    check_eq("rst_rdata", bus.o_mem_rdata, '0);
    check_eq("rst_count", o_count, 3'd0);
    check_eq("rst_err", o_err, 1'b0);
    check_eq("rst_ready", bus.i_ret_ready, 1'b1);
    g_resetn = 1'b1;

    // 1: non-memory record, two-cycle latency (first release may be masked)
    push(rec_a, 1'b0);
    tick(); idle();
    check_eq("t1_n1_valid", bus.o_valid, 1'b0);
    check_eq("t1_n1_count", o_count, 3'd1);
    tick();
    check_eq("t1_valid", bus.o_valid, !DROP_FIRST);
    check_eq("t1_rec", bus.o_rec, DROP_FIRST ? '0 : rec_a);
    check_eq("t1_rdata", bus.o_mem_rdata, 64'd0);
    check_eq("t1_count", o_count, 3'd0);
    tick();
    check_eq("t1_pulse_end", bus.o_valid, 1'b0);

    // 2: load L waits for its response, ALU op B stays behind it
    push(rec_l, 1'b1);
    tick();
    push(rec_b, 1'b0);
    tick(); idle();
    for (int k = 0; k < 4; k++) tick();
    check_eq("t2_c6_valid", bus.o_valid, 1'b0);
    check_eq("t2_c6_count", o_count, 3'd2);
    rsp(64'hDEAD);
    tick(); idle();
    check_eq("t2_c7_valid", bus.o_valid, 1'b0);
    push(rec_c, 1'b0);
    tick(); idle();
    check_eq("t2_c8_valid", bus.o_valid, 1'b1);
    check_eq("t2_c8_rec", bus.o_rec, rec_l);
    check_eq("t2_c8_rdata", bus.o_mem_rdata, 64'hDEAD);
    check_eq("t2_c8_count", o_count, 3'd2);
    tick();
    check_eq("t2_c9_valid", bus.o_valid, 1'b1);
    check_eq("t2_c9_rec", bus.o_rec, rec_b);
    check_eq("t2_c9_rdata", bus.o_mem_rdata, 64'd0);
    check_eq("t2_c9_count", o_count, 3'd1);
    tick();
    check_eq("t2_c_rec", bus.o_rec, rec_c);
    check_eq("t2_c_count", o_count, 3'd0);
    tick();
    check_eq("t2_idle", bus.o_valid, 1'b0);

    // 4: memory record and its response in the same cycle
    push(rec_m, 1'b1);
    rsp(64'hBEEF);
    tick(); idle();
    check_eq("t4_n1_valid", bus.o_valid, 1'b0);
    check_eq("t4_n1_count", o_count, 3'd1);
    tick();
    check_eq("t4_valid", bus.o_valid, 1'b1);
    check_eq("t4_rec", bus.o_rec, rec_m);
    check_eq("t4_rdata", bus.o_mem_rdata, 64'hBEEF);
    check_eq("t4_err", o_err, 1'b0);

    // 5: response with nothing outstanding
    tick();
    rsp(64'h1234);
    tick(); idle();
    check_eq("t5_err", o_err, 1'b1);
    check_eq("t5_valid", bus.o_valid, 1'b0);
    check_eq("t5_count", o_count, 3'd0);

    g_resetn = 1'b0;
    tick();
    g_resetn = 1'b1;
    check_eq("rst2_err", o_err, 1'b0);

    // 3: fill with memory records, overflow, then a pop from full
    for (int k = 0; k < DEPTH; k++) begin
      push(rec_r[k], 1'b1);
      tick();
    end
    idle();
    check_eq("t3_full_ready", bus.i_ret_ready, 1'b0);
    check_eq("t3_full_count", o_count, 3'd4);
    check_eq("t3_full_err", o_err, 1'b0);
    push(rec_r[4], 1'b0);
    tick(); idle();
    check_eq("t3_ovf_err", o_err, 1'b1);
    check_eq("t3_ovf_count", o_count, 3'd4);
    rsp(64'h111);
    tick(); idle();
    check_eq("t3_pop_ready", bus.i_ret_ready, 1'b0);
    check_eq("t3_pop_count", o_count, 3'd4);
    tick();
    check_eq("t3_rel_count", o_count, 3'd3);
    check_eq("t3_rel_ready", bus.i_ret_ready, 1'b1);
    check_eq("t3_rel_valid", bus.o_valid, !DROP_FIRST);
    check_eq("t3_rel_rec", bus.o_rec, DROP_FIRST ? '0 : rec_r[0]);
    check_eq("t3_rel_rdata", bus.o_mem_rdata, DROP_FIRST ? 64'd0 : 64'h111);

    // 6: reset with three pending, then a late response
    g_resetn = 1'b0;
    tick();
    g_resetn = 1'b1;
    check_eq("t6_count", o_count, 3'd0);
    check_eq("t6_valid", bus.o_valid, 1'b0);
    check_eq("t6_err", o_err, 1'b0);
    rsp(64'h222);
    tick(); idle();
    check_eq("t6_late_err", o_err, 1'b1);
    check_eq("t6_late_valid", bus.o_valid, 1'b0);
    check_eq("t6_late_count", o_count, 3'd0);
    tick();
    check_eq("t6_quiet", bus.o_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
